// File: rtl/regfile_access_arbiter.sv
// Two-client round-robin arbiter in front of a small register file.
// One granted request per cycle reads up to two registers, optionally
// writes one register, and produces exactly one registered response
// one cycle later. A stalled response channel blocks all new grants.
module regfile_access_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    // client A
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [1:0]        a_op,
    input  logic [ADDR_W-1:0] a_dst,
    input  logic [ADDR_W-1:0] a_src1,
    input  logic [ADDR_W-1:0] a_src2,
    input  logic [DATA_W-1:0] a_wdata,
    // client B
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_op,
    input  logic [ADDR_W-1:0] b_dst,
    input  logic [ADDR_W-1:0] b_src1,
    input  logic [ADDR_W-1:0] b_src2,
    input  logic [DATA_W-1:0] b_wdata,
    // register file ports
    output logic [ADDR_W-1:0] rf_rr1,
    output logic [ADDR_W-1:0] rf_rr2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    // response channel
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    // statistics
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ADD   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // registered state
    logic              last_b_q,    last_b_d;     // 1: B was granted most recently
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic [7:0]        op_count_q,  op_count_d;

    // combinational intermediates
    logic              stall_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              grant_s;
    op_e               sel_op_s;
    logic [ADDR_W-1:0] sel_dst_s;
    logic [ADDR_W-1:0] sel_src1_s;
    logic [ADDR_W-1:0] sel_src2_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] result_s;

    // Round-robin arbitration; no grant while reset is high or the response is stalled.
    always_comb begin
        stall_s   = rsp_valid_q & ~rsp_ready;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (reset || stall_s) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_valid && b_valid) begin
            if (last_b_q) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (a_valid) begin
            grant_a_s = 1'b1;
        end else if (b_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
        grant_s = grant_a_s | grant_b_s;
    end

    // Select the fields of the request that won arbitration.
    always_comb begin
        sel_op_s    = op_e'(a_op);
        sel_dst_s   = a_dst;
        sel_src1_s  = a_src1;
        sel_src2_s  = a_src2;
        sel_wdata_s = a_wdata;
        if (grant_b_s) begin
            sel_op_s    = op_e'(b_op);
            sel_dst_s   = b_dst;
            sel_src1_s  = b_src1;
            sel_src2_s  = b_src2;
            sel_wdata_s = b_wdata;
        end else begin
            sel_op_s    = op_e'(a_op);
            sel_dst_s   = a_dst;
            sel_src1_s  = a_src1;
            sel_src2_s  = a_src2;
            sel_wdata_s = a_wdata;
        end
    end

    // Drive the register-file ports and form the response value for the granted op.
    // ADD reads its sources combinationally in the grant cycle, so a destination
    // that aliases a source naturally uses the pre-write value.
    always_comb begin
        sum_s    = rf_rd1 + rf_rd2;
        rf_rr1   = {ADDR_W{1'b0}};
        rf_rr2   = {ADDR_W{1'b0}};
        rf_we    = 1'b0;
        rf_wr    = {ADDR_W{1'b0}};
        rf_wdata = {DATA_W{1'b0}};
        result_s = {DATA_W{1'b0}};
        if (grant_s) begin
            rf_rr1 = sel_src1_s;
            rf_rr2 = sel_src2_s;
            case (sel_op_s)
                OP_READ: begin
                    result_s = rf_rd1;
                end
                OP_WRITE: begin
                    rf_we    = 1'b1;
                    rf_wr    = sel_dst_s;
                    rf_wdata = sel_wdata_s;
                    result_s = sel_wdata_s;
                end
                OP_ADD: begin
                    rf_we    = 1'b1;
                    rf_wr    = sel_dst_s;
                    rf_wdata = sum_s;
                    result_s = sum_s;
                end
                OP_CLEAR: begin
                    rf_we    = 1'b1;
                    rf_wr    = sel_dst_s;
                    rf_wdata = {DATA_W{1'b0}};
                    result_s = {DATA_W{1'b0}};
                end
                default: begin
                    rf_we    = 1'b0;
                    result_s = {DATA_W{1'b0}};
                end
            endcase
        end else begin
            rf_we = 1'b0;
        end
    end

    // Next-state for the response register, grant counter and round-robin pointer.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        op_count_d  = op_count_q;
        last_b_d    = last_b_q;
        if (grant_s) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_b_s;
            rsp_data_d  = result_s;
            op_count_d  = op_count_q + 8'd1;
            last_b_d    = grant_b_s;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers; reset points the round-robin at B so A wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
            op_count_q  <= 8'd0;
            last_b_q    <= 1'b1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
            last_b_q    <= last_b_d;
        end
    end

    assign a_ready   = grant_a_s;
    assign b_ready   = grant_b_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed vector table, stall/reset/wrap
// sequences and randomized traffic checked against a behavioural model.
module tb_regfile_access_arbiter;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] AD = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [1:0] a_op, b_op;
    logic [1:0] a_dst, a_src1, a_src2, b_dst, b_src1, b_src2;
    logic [7:0] a_wdata, b_wdata;
    logic [1:0] rf_rr1, rf_rr2, rf_wr;
    logic [7:0] rf_rd1, rf_rd2, rf_wdata;
    logic       rf_we;
    logic       rsp_valid, rsp_id, rsp_ready;
    logic [7:0] rsp_data, op_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_dst(a_dst),
        .a_src1(a_src1), .a_src2(a_src2), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_dst(b_dst),
        .b_src1(b_src1), .b_src2(b_src2), .b_wdata(b_wdata),
        .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_wr(rf_wr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .op_count(op_count)
    );

    // register file attached to the DUT
    logic [7:0] rf_mem [4];
    assign rf_rd1 = rf_mem[rf_rr1];
    assign rf_rd2 = rf_mem[rf_rr2];
    // write port of the attached register file
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_wr] <= rf_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_rf [4];
    bit         m_valid;
    int         m_id;
    int         m_data;
    int         m_count;
    int         m_last;   // client granted most recently (0=A, 1=B)

    task automatic model_reset();
        m_valid = 1'b0; m_id = 0; m_data = 0; m_count = 0; m_last = 1;
    endtask

    // Predict this cycle's outputs, optionally compare, then advance the model.
    task automatic model_cycle(input bit do_check, input string tag);
        int win, op, dst, s1, s2, wd, res, e_wr, e_wd, e_rr1, e_rr2;
        bit writes;
        win = -1;
        if (!(m_valid && !rsp_ready)) begin
            if (a_valid && b_valid) win = (m_last == 1) ? 0 : 1;
            else if (a_valid)       win = 0;
            else if (b_valid)       win = 1;
        end
        op = 0; dst = 0; s1 = 0; s2 = 0; wd = 0;
        if (win == 0) begin op = a_op; dst = a_dst; s1 = a_src1; s2 = a_src2; wd = a_wdata; end
        if (win == 1) begin op = b_op; dst = b_dst; s1 = b_src1; s2 = b_src2; wd = b_wdata; end
        case (op)
            0:       res = m_rf[s1];
            1:       res = wd;
            2:       res = (m_rf[s1] + m_rf[s2]) % 256;
            default: res = 0;
        endcase
        writes = (win >= 0) && (op != 0);
        e_wr  = writes ? dst : 0;
        e_wd  = writes ? res : 0;
        e_rr1 = (win >= 0) ? s1 : 0;
        e_rr2 = (win >= 0) ? s2 : 0;
        if (do_check) begin
            chk({tag, " a_ready"},   32'(a_ready),   32'(win == 0));
            chk({tag, " b_ready"},   32'(b_ready),   32'(win == 1));
            chk({tag, " rf_we"},     32'(rf_we),     32'(writes));
            chk({tag, " rf_wr"},     32'(rf_wr),     32'(e_wr));
            chk({tag, " rf_wdata"},  32'(rf_wdata),  32'(e_wd));
            chk({tag, " rf_rr1"},    32'(rf_rr1),    32'(e_rr1));
            chk({tag, " rf_rr2"},    32'(rf_rr2),    32'(e_rr2));
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
            chk({tag, " op_count"},  32'(op_count),  32'(m_count));
            if (m_valid) begin
                chk({tag, " rsp_id"},   32'(rsp_id),   32'(m_id));
                chk({tag, " rsp_data"}, 32'(rsp_data), 32'(m_data));
            end
        end
        if (win >= 0) begin
            if (writes) m_rf[dst] = res;
            m_valid = 1'b1; m_id = win; m_data = res;
            m_count = (m_count + 1) % 256;
            m_last  = win;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // one clock cycle: inputs already set at the falling edge
    task automatic cyc(input bit do_check, input string tag);
        #2;
        model_cycle(do_check, tag);
        @(negedge clk);
    endtask

    task automatic set_a(input logic v, input logic [1:0] op, input logic [1:0] d,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] w);
        a_valid = v; a_op = op; a_dst = d; a_src1 = s1; a_src2 = s2; a_wdata = w;
    endtask

    task automatic set_b(input logic v, input logic [1:0] op, input logic [1:0] d,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] w);
        b_valid = v; b_op = op; b_dst = d; b_src1 = s1; b_src2 = s2; b_wdata = w;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       av; logic [1:0] aop, adst, as1, as2; logic [7:0] awd;
        logic       bv; logic [1:0] bop, bdst, bs1, bs2; logic [7:0] bwd;
        logic       rr;
        logic       ea, eb, ewe; logic [1:0] ewr; logic [7:0] ewd; logic [1:0] err1, err2;
        logic       ev, eid; logic [7:0] edata, ecnt;
    } vec_t;

    vec_t vt [11];

    initial begin
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        model_reset();
        reset = 1'b1; rsp_ready = 1'b1;
        set_a(1'b1, WR, 2'd1, 2'd0, 2'd0, 8'h77);
        set_b(1'b1, WR, 2'd2, 2'd0, 2'd0, 8'h66);

        //        av   aop adst   as1    as2    awd     bv   bop bdst   bs1    bs2    bwd     rr    ea   eb   ewe  ewr    ewd     err1   err2   ev   eid  edata   ecnt
        vt[0]  = '{1'b1, WR, 2'd2, 2'd0, 2'd0, 8'h5A, 1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b1,1'b0,1'b1, 2'd2, 8'h5A, 2'd0, 2'd0, 1'b0,1'b0, 8'h00, 8'd0};
        vt[1]  = '{1'b1, WR, 2'd0, 2'd0, 2'd0, 8'hF0, 1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b1,1'b0,1'b1, 2'd0, 8'hF0, 2'd0, 2'd0, 1'b1,1'b0, 8'h5A, 8'd1};
        vt[2]  = '{1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, WR, 2'd1, 2'd0, 2'd0, 8'h20, 1'b1, 1'b0,1'b1,1'b1, 2'd1, 8'h20, 2'd0, 2'd0, 1'b1,1'b0, 8'hF0, 8'd2};
        vt[3]  = '{1'b1, AD, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b1,1'b0,1'b1, 2'd3, 8'h10, 2'd0, 2'd1, 1'b1,1'b1, 8'h20, 8'd3};
        vt[4]  = '{1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, RD, 2'd0, 2'd3, 2'd0, 8'h00, 1'b1, 1'b0,1'b1,1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 1'b1,1'b0, 8'h10, 8'd4};
        vt[5]  = '{1'b1, RD, 2'd0, 2'd2, 2'd0, 8'h00, 1'b1, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b1,1'b0,1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b1,1'b1, 8'h10, 8'd5};
        vt[6]  = '{1'b1, RD, 2'd0, 2'd2, 2'd0, 8'h00, 1'b1, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0,1'b1,1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1,1'b0, 8'h5A, 8'd6};
        vt[7]  = '{1'b1, RD, 2'd0, 2'd2, 2'd0, 8'h00, 1'b1, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b1,1'b0,1'b0, 2'd0, 8'h00, 2'd2, 2'd0, 1'b1,1'b1, 8'hF0, 8'd7};
        vt[8]  = '{1'b1, RD, 2'd0, 2'd2, 2'd0, 8'h00, 1'b1, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0,1'b1,1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1,1'b0, 8'h5A, 8'd8};
        vt[9]  = '{1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0,1'b0,1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b1,1'b1, 8'hF0, 8'd9};
        vt[10] = '{1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 1'b0,1'b0,1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0,1'b0, 8'h00, 8'd9};

        // reset held with writes requested: nothing granted or written
        #22;
        chk("reset a_ready",   32'(a_ready),   32'd0);
        chk("reset b_ready",   32'(b_ready),   32'd0);
        chk("reset rf_we",     32'(rf_we),     32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id",    32'(rsp_id),    32'd0);
        chk("reset rsp_data",  32'(rsp_data),  32'd0);
        chk("reset op_count",  32'(op_count),  32'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            set_a(vt[i].av, vt[i].aop, vt[i].adst, vt[i].as1, vt[i].as2, vt[i].awd);
            set_b(vt[i].bv, vt[i].bop, vt[i].bdst, vt[i].bs1, vt[i].bs2, vt[i].bwd);
            rsp_ready = vt[i].rr;
            #2;
            chk($sformatf("vec%0d a_ready", i),   32'(a_ready),   32'(vt[i].ea));
            chk($sformatf("vec%0d b_ready", i),   32'(b_ready),   32'(vt[i].eb));
            chk($sformatf("vec%0d rf_we", i),     32'(rf_we),     32'(vt[i].ewe));
            chk($sformatf("vec%0d rf_wr", i),     32'(rf_wr),     32'(vt[i].ewr));
            chk($sformatf("vec%0d rf_wdata", i),  32'(rf_wdata),  32'(vt[i].ewd));
            chk($sformatf("vec%0d rf_rr1", i),    32'(rf_rr1),    32'(vt[i].err1));
            chk($sformatf("vec%0d rf_rr2", i),    32'(rf_rr2),    32'(vt[i].err2));
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d op_count", i),  32'(op_count),  32'(vt[i].ecnt));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d rsp_id", i),   32'(rsp_id),   32'(vt[i].eid));
                chk($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(vt[i].edata));
            end
            model_cycle(1'b0, "table");
            @(negedge clk);
        end

        // stall: one grant, then three cycles of rsp_ready low, then resume
        set_a(1'b1, WR, 2'd1, 2'd0, 2'd0, 8'h3C);
        set_b(1'b1, WR, 2'd2, 2'd0, 2'd0, 8'hC3);
        rsp_ready = 1'b1;
        cyc(1'b1, "stall_pre");
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall a_ready",   32'(a_ready),   32'd0);
            chk("stall b_ready",   32'(b_ready),   32'd0);
            chk("stall rf_we",     32'(rf_we),     32'd0);
            chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall rsp_data",  32'(rsp_data),  32'h3C);
            model_cycle(1'b1, "stall");
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #2;
        chk("resume b_ready", 32'(b_ready), 32'd1);
        model_cycle(1'b1, "resume");
        @(negedge clk);

        // asynchronous reset while a response is pending
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst op_count",  32'(op_count),  32'd0);
        chk("midrst a_ready",   32'(a_ready),   32'd0);
        chk("midrst b_ready",   32'(b_ready),   32'd0);
        chk("midrst rf_we",     32'(rf_we),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        set_a(1'b1, RD, 2'd0, 2'd1, 2'd2, 8'h00);
        set_b(1'b1, RD, 2'd0, 2'd2, 2'd1, 8'h00);
        #2;
        chk("postrst a_ready", 32'(a_ready), 32'd1);
        chk("postrst b_ready", 32'(b_ready), 32'd0);
        model_cycle(1'b1, "postrst");
        @(negedge clk);

        // 255 more back-to-back grants bring op_count round to zero
        for (int i = 0; i < 255; i++) cyc(1'b1, "wrap");
        set_a(1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00);
        set_b(1'b0, RD, 2'd0, 2'd0, 2'd0, 8'h00);
        #2;
        chk("wrap op_count", 32'(op_count), 32'd0);
        model_cycle(1'b1, "wrap_end");
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            set_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc(1'b1, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_access_arbiter.md
REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 2, register address width (4 registers).
REQ-003 The block SHALL use reset, asynchronous, active-high, and clock clk.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  async active-high reset.
REQ-006 a_valid, b_valid  in  1 each  request present from client A / B.
REQ-007 a_ready, b_ready  out  1 each  request accepted this cycle (grant = valid & ready).
REQ-008 a_op, b_op  in  2 each  00 READ, 01 WRITE, 10 ADD, 11 CLEAR.
REQ-009 a_dst/a_src1/a_src2, b_dst/b_src1/b_src2  in  ADDR_W each  destination and source register indices.
REQ-010 a_wdata, b_wdata  in  DATA_W each  WRITE data.
REQ-011 rf_rr1, rf_rr2  out  ADDR_W each  register-file read addresses.
REQ-012 rf_rd1, rf_rd2  in  DATA_W each  register-file combinational read data.
REQ-013 rf_wr  out  ADDR_W, rf_wdata  out  DATA_W, rf_we  out  1  register-file write port.
REQ-014 rsp_valid  out  1, rsp_id  out  1 (0=A,1=B), rsp_data  out  DATA_W, rsp_ready  in  1  response channel.
REQ-015 op_count  out  8  completed-grant counter.

Function
REQ-016 The block SHALL grant at most one request per cycle.
REQ-017 Arbitration SHALL be round-robin: both valid -> grant client not granted last; one valid -> grant it.
REQ-018 a_ready/b_ready SHALL be combinational, high only for the selected valid client, and low while rsp_valid=1 and rsp_ready=0 (stall).
REQ-019 In the grant cycle rf_rr1=src1, rf_rr2=src2 of the granted request; with no grant rf_we=0 and rf_rr1/rf_rr2/rf_wr/rf_wdata=0.
REQ-020 READ: rf_we=0; response data = rf_rd1 sampled at grant edge.
REQ-021 WRITE: rf_we=1, rf_wr=dst, rf_wdata=wdata; response data = wdata.
REQ-022 ADD: rf_we=1, rf_wr=dst, rf_wdata=(rf_rd1+rf_rd2) mod 2^DATA_W, carry discarded; response data = sum; dst equal to a source uses pre-write value.
REQ-023 CLEAR: rf_we=1, rf_wr=dst, rf_wdata=0; response data = 0.
REQ-024 Every grant SHALL produce exactly one response: rsp_valid=1 with rsp_id and rsp_data on the cycle after grant (latency 1).
REQ-025 rsp_valid, rsp_id, rsp_data SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-026 rsp_valid=1, rsp_ready=1 with a new grant same cycle -> rsp_valid stays 1, next response loaded; without a grant -> rsp_valid clears.
REQ-027 A write granted in cycle N SHALL be visible to a READ granted in cycle N+1.
REQ-028 op_count SHALL increment by 1 per grant, wrapping 255 -> 0.

Reset
REQ-029 On reset assertion, immediately: rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, rf_we=0, a_ready=b_ready=0.
REQ-030 Round-robin pointer SHALL reset to "last granted B" so A wins the first contended grant.
REQ-031 Reset mid-transaction SHALL discard any pending response; no write is issued while reset is high.

Verification
REQ-032 After reset, A WRITE dst=2 wdata=0x5A, rsp_ready=1 -> grant cycle rf_we=1 rf_wr=2 rf_wdata=0x5A; next cycle rsp_valid=1 rsp_id=0 rsp_data=0x5A; op_count=1.
REQ-033 A and B both valid READ for 4 cycles, rsp_ready=1 -> grants A,B,A,B; rsp_id 0,1,0,1 each one cycle later.
REQ-034 ADD src1=0 (0xF0) src2=1 (0x20) dst=3 -> rf_wdata=0x10, rsp_data=0x10; following READ src1=3 returns 0x10.
REQ-035 rsp_ready=0 for 3 cycles with both clients valid -> a_ready=b_ready=0, rf_we=0, response outputs unchanged; rsp_ready=1 resumes grants.
REQ-036 reset asserted while rsp_valid=1 -> rsp_valid=0 and op_count=0 before next clk edge; first grant after release goes to A.
REQ-037 256 consecutive grants -> op_count returns to 0.
